// File: rtl/eq_pkg.sv
// Shared equalizer definitions: sample/coefficient formats,
// FSM encoding and output saturation limits.
package eq_pkg;

    localparam int DATA_W = 29;
    localparam int COEF_W = 18;
    localparam int FRAC   = 14;
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int ONE    = 16384;

    localparam longint SAT_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam longint SAT_MIN = -(64'sd1 <<< (DATA_W - 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } state_e;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchronizer plus falling-edge detector.
// Ports: clk, rst_n (async low), strobe_i (async), pulse_o (1-clk on fall).
module strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_i,
    output logic pulse_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= strobe_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // s3_q is the previous synchronized level; one pulse per fall
    assign pulse_o = s3_q & ~s2_q;

endmodule

// File: rtl/eq_biquad_band.sv
// One EQ band: direct-form-I biquad, one shared multiplier over 5 taps.
// Ports: clk, Reset (async low), in_strobe/in_data (ADC side), bypass,
//        out_data/out_valid, busy, overrun (sticky).
module eq_biquad_band
    import eq_pkg::*;
#(
    parameter int signed B0 = ONE,
    parameter int signed B1 = 0,
    parameter int signed B2 = 0,
    parameter int signed A1 = 0,
    parameter int signed A2 = 0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              in_strobe,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bypass,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] LIM_LO = ACC_W'(SAT_MIN);

    logic cap;

    strobe_sync u_sync (
        .clk      (clk),
        .rst_n    (Reset),
        .strobe_i (in_strobe),
        .pulse_o  (cap)
    );

    state_e                    state_q;
    logic [2:0]                tap_q;
    logic signed [DATA_W-1:0]  x_q, x1_q, x2_q, y1_q, y2_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [DATA_W-1:0]         out_data_q;
    logic                      out_valid_q, busy_q, overrun_q;

    logic signed [COEF_W:0]        coef;
    logic signed [DATA_W-1:0]      opnd;
    logic signed [COEF_W+DATA_W:0] prod;
    logic signed [ACC_W-1:0]       prod_ext, rnd, shifted;
    logic signed [DATA_W-1:0]      y_d;

    // Coefficients carry one extra bit so negating A1/A2 cannot overflow
    always_comb begin
        coef = '0;
        opnd = '0;
        unique case (tap_q)
            3'd0: begin coef = (COEF_W+1)'(B0);  opnd = x_q;  end
            3'd1: begin coef = (COEF_W+1)'(B1);  opnd = x1_q; end
            3'd2: begin coef = (COEF_W+1)'(B2);  opnd = x2_q; end
            3'd3: begin coef = (COEF_W+1)'(-A1); opnd = y1_q; end
            3'd4: begin coef = (COEF_W+1)'(-A2); opnd = y2_q; end
            default: begin coef = '0; opnd = '0; end
        endcase
    end

    assign prod     = coef * opnd;
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        rnd     = acc_q + HALF;
        shifted = rnd >>> FRAC;
        if (shifted > LIM_HI)
            y_d = DATA_W'(SAT_MAX);
        else if (shifted < LIM_LO)
            y_d = DATA_W'(SAT_MIN);
        else
            y_d = shifted[DATA_W-1:0];
        if (bypass)
            y_d = x_q;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            x_q         <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (cap && state_q != ST_IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    // busy drops the cycle after out_valid unless a new sample lands
                    busy_q <= cap;
                    if (cap) begin
                        x_q     <= in_data;
                        acc_q   <= '0;
                        tap_q   <= '0;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + prod_ext;
                    if (tap_q == 3'd4)
                        state_q <= ST_ROUND;
                    else
                        tap_q <= tap_q + 3'd1;
                end
                ST_ROUND: begin
                    out_data_q  <= y_d;
                    out_valid_q <= 1'b1;
                    x2_q        <= x1_q;
                    x1_q        <= x_q;
                    y2_q        <= y1_q;
                    y1_q        <= y_d;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_eq_biquad_band.sv
// Directed self-checking bench for eq_biquad_band using four
// differently-coefficiented instances driven by shared stimulus.
module tb_eq_biquad_band;

    logic        clk = 1'b0;
    logic        Reset;
    logic        in_strobe;
    logic [28:0] in_data;
    logic        bypass;

    logic [28:0] od  [4];
    logic        ov  [4];
    logic        bz  [4];
    logic        orn [4];

    int n_cmp  = 0;
    int n_fail = 0;

    int          bidx, vidx, nv;
    logic        busy_after;
    logic [28:0] cod [4];
    logic        found;

    always #5 clk = ~clk;

    // 0: identity, 1: one-pole lowpass, 2: gain 4, 3: zero gain
    eq_biquad_band #(.B0(16384)) u_id (
        .clk(clk), .Reset(Reset), .in_strobe(in_strobe), .in_data(in_data),
        .bypass(bypass), .out_data(od[0]), .out_valid(ov[0]),
        .busy(bz[0]), .overrun(orn[0]));

    eq_biquad_band #(.B0(8192), .A1(-8192)) u_imp (
        .clk(clk), .Reset(Reset), .in_strobe(in_strobe), .in_data(in_data),
        .bypass(bypass), .out_data(od[1]), .out_valid(ov[1]),
        .busy(bz[1]), .overrun(orn[1]));

    eq_biquad_band #(.B0(65536)) u_sat (
        .clk(clk), .Reset(Reset), .in_strobe(in_strobe), .in_data(in_data),
        .bypass(bypass), .out_data(od[2]), .out_valid(ov[2]),
        .busy(bz[2]), .overrun(orn[2]));

    eq_biquad_band #(.B0(0)) u_byp (
        .clk(clk), .Reset(Reset), .in_strobe(in_strobe), .in_data(in_data),
        .bypass(bypass), .out_data(od[3]), .out_valid(ov[3]),
        .busy(bz[3]), .overrun(orn[3]));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
    endtask

    // Watch u_id for maxc cycles; record first busy, first valid, outputs
    task automatic observe(input int maxc);
        bidx = -1;
        vidx = -1;
        nv   = 0;
        busy_after = 1'bx;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bidx < 0 && bz[0]) bidx = i;
            if (vidx >= 0 && i == vidx + 1) busy_after = bz[0];
            if (ov[0]) begin
                nv++;
                if (vidx < 0) begin
                    vidx = i;
                    for (int k = 0; k < 4; k++) cod[k] = od[k];
                end
            end
        end
    endtask

    task automatic drive(input logic [28:0] d, input int hi);
        @(negedge clk);
        in_data   = d;
        in_strobe = 1'b1;
        repeat (hi) @(negedge clk);
        in_strobe = 1'b0;
    endtask

    task automatic sample(input logic [28:0] d, input int hi);
        drive(d, hi);
        observe(20);
    endtask

    task automatic wait_busy();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bz[0]) found = 1'b1;
        end
    endtask

    initial begin
        Reset     = 1'b0;
        in_strobe = 1'b0;
        in_data   = '0;
        bypass    = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_out_data",  od[0],  29'd0);
        chk("rst_out_valid", ov[0],  1'b0);
        chk("rst_busy",      bz[0],  1'b0);
        chk("rst_overrun",   orn[0], 1'b0);
        Reset = 1'b1;

        // Identity with a very long strobe
        drive(29'd2048, 4167);
        observe(30);
        chk("id_busy_seen", bidx >= 0, 1'b1);
        chk("id_latency",   vidx - bidx, 6);
        chk("id_nvalid",    nv, 1);
        chk("id_data",      cod[0], 29'd2048);
        chk("id_busy_fall", busy_after, 1'b0);
        chk("id_overrun",   orn[0], 1'b0);

        // Impulse through y = 0.5x + 0.5y1
        do_reset();
        sample(29'd16384, 2);
        chk("imp_0", cod[1], 29'd8192);
        sample(29'd0, 2);
        chk("imp_1", cod[1], 29'd4096);
        sample(29'd0, 2);
        chk("imp_2", cod[1], 29'd2048);
        sample(29'd0, 2);
        chk("imp_3", cod[1], 29'd1024);

        // Reset in the middle of MAC discards the sample and history
        drive(29'd0, 2);
        wait_busy();
        chk("rst_busy_found", found, 1'b1);
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        #1;
        chk("midrst_out_data",  od[1], 29'd0);
        chk("midrst_out_valid", ov[1], 1'b0);
        chk("midrst_busy",      bz[1], 1'b0);
        @(negedge clk);
        Reset = 1'b1;
        observe(20);
        chk("midrst_no_valid", nv, 0);
        sample(29'd16384, 2);
        chk("midrst_zero_hist", cod[1], 29'd8192);

        // Saturation at both rails
        do_reset();
        sample(29'h0FFF_FFFF, 2);
        chk("sat_pos", cod[2], 29'h0FFF_FFFF);
        sample(29'h1000_0000, 2);
        chk("sat_neg", cod[2], 29'h1000_0000);
        sample(29'd1000, 2);
        chk("sat_inrange", cod[2], 29'd4000);

        // Second strobe lands during MAC
        do_reset();
        drive(29'd100, 2);
        wait_busy();
        chk("ovr_busy_found", found, 1'b1);
        in_strobe = 1'b1;
        repeat (2) @(negedge clk);
        in_strobe = 1'b0;
        in_data   = 29'd777;
        observe(30);
        chk("ovr_nvalid", nv, 1);
        chk("ovr_data",   cod[0], 29'd100);
        chk("ovr_flag",   orn[0], 1'b1);
        sample(29'd200, 2);
        chk("ovr_next_data", cod[0], 29'd200);
        chk("ovr_next_cnt",  nv, 1);
        chk("ovr_sticky",    orn[0], 1'b1);

        // Bypass with zero gain, then normal path
        do_reset();
        bypass = 1'b1;
        sample(29'h1FFF_FFFB, 2);
        chk("byp_on",  cod[3], 29'h1FFF_FFFB);
        bypass = 1'b0;
        sample(29'd0, 2);
        chk("byp_off", cod[3], 29'd0);
        sample(29'd50, 2);
        chk("byp_off_gain0", cod[3], 29'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
